// File: rtl/eth_axil_regs.sv
// AXI4-Lite control/status register block: writes commit one cycle after AW+W are both held, reads answer one cycle after AR.
// One outstanding B and one outstanding R; readies drop while a response waits. Define ETH_AXIL_W1C_EN for sticky write-1-to-clear status.
module eth_axil_regs #(
    parameter int ADDR_W = 8,
    parameter int N_CTRL = 4,
    parameter int N_STAT = 4
) (
    input  logic                AXI_Clk,
    input  logic                AXI_Rstn,
    input  logic                AXI_awvalid,
    output logic                AXI_awready,
    input  logic [ADDR_W-1:0]   AXI_awaddr,
    input  logic                AXI_wvalid,
    output logic                AXI_wready,
    input  logic [31:0]         AXI_wdata,
    input  logic [3:0]          AXI_wstrb,
    output logic                AXI_bvalid,
    output logic [1:0]          AXI_bresp,
    input  logic                AXI_bready,
    input  logic                AXI_arvalid,
    output logic                AXI_arready,
    input  logic [ADDR_W-1:0]   AXI_araddr,
    output logic                AXI_rvalid,
    output logic [31:0]         AXI_rdata,
    output logic [1:0]          AXI_rresp,
    input  logic                AXI_rready,
    output logic [N_CTRL*32-1:0] Ctrl_Regs,
    output logic [N_CTRL-1:0]   Ctrl_Wr_Pulse,
    input  logic [N_STAT*32-1:0] Stat_In
);
    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W:0] MAP_END = (IDX_W+1)'(N_CTRL + N_STAT);

    logic                  aw_held;
    logic                  w_held;
    logic [IDX_W-1:0]      aw_idx;
    logic [31:0]           w_dat;
    logic [3:0]            w_strb;
    logic [N_CTRL*32-1:0]  ctrl_q;
    logic [N_CTRL-1:0]     wr_pulse;
    logic                  bvalid;
    logic [1:0]            bresp;
    logic                  rvalid;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  commit;
    logic                  wr_mapped;
    logic [31:0]           wmask;
    logic [IDX_W-1:0]      ar_idx;
    logic                  rd_mapped;
    logic [31:0]           rd_val;
    logic [N_STAT*32-1:0]  stat_src;
    logic                  unused_addr_bits;

    // Byte lane bits of both addresses are don't-care.
    assign unused_addr_bits = ^{AXI_awaddr[1:0], AXI_araddr[1:0]};

    // Readies are gated by reset so they read 0 while reset is held and rise right after release.
    assign AXI_awready   = AXI_Rstn & ~aw_held & ~bvalid;
    assign AXI_wready    = AXI_Rstn & ~w_held & ~bvalid;
    assign AXI_arready   = AXI_Rstn & ~rvalid;
    assign AXI_bvalid    = bvalid;
    assign AXI_bresp     = bresp;
    assign AXI_rvalid    = rvalid;
    assign AXI_rdata     = rdata;
    assign AXI_rresp     = rresp;
    assign Ctrl_Regs     = ctrl_q;
    assign Ctrl_Wr_Pulse = wr_pulse;

    assign commit    = aw_held & w_held & ~bvalid;
    assign wr_mapped = {1'b0, aw_idx} < MAP_END;
    assign wmask     = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};

    always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
        if (!AXI_Rstn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx   <= '0;
            w_dat    <= '0;
            w_strb   <= '0;
            ctrl_q   <= '0;
            wr_pulse <= '0;
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
        end else begin
            wr_pulse <= '0;
            if (AXI_awvalid && AXI_awready) begin
                aw_held <= 1'b1;
                aw_idx  <= AXI_awaddr[ADDR_W-1:2];
            end
            if (AXI_wvalid && AXI_wready) begin
                w_held <= 1'b1;
                w_dat  <= AXI_wdata;
                w_strb <= AXI_wstrb;
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= wr_mapped ? 2'b00 : 2'b10;
                for (int i = 0; i < N_CTRL; i++) begin
                    if (aw_idx == IDX_W'(i)) begin
                        ctrl_q[32*i +: 32] <= (ctrl_q[32*i +: 32] & ~wmask) | (w_dat & wmask);
                        wr_pulse[i]        <= 1'b1;
                    end
                end
            end else if (bvalid && AXI_bready) begin
                // Captures stay held until the response is taken, which keeps readies low.
                bvalid  <= 1'b0;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

`ifdef ETH_AXIL_W1C_EN
    logic [N_STAT*32-1:0] stat_q;

    // New events OR in after the clear, so a bit arriving in the clear cycle survives.
    always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
        if (!AXI_Rstn) begin
            stat_q <= '0;
        end else begin
            for (int j = 0; j < N_STAT; j++) begin
                if (commit && aw_idx == IDX_W'(N_CTRL + j))
                    stat_q[32*j +: 32] <= (stat_q[32*j +: 32] & ~(w_dat & wmask)) | Stat_In[32*j +: 32];
                else
                    stat_q[32*j +: 32] <= stat_q[32*j +: 32] | Stat_In[32*j +: 32];
            end
        end
    end

    assign stat_src = stat_q;
`else
    assign stat_src = Stat_In;
`endif

    assign ar_idx = AXI_araddr[ADDR_W-1:2];

    always_comb begin
        rd_val    = '0;
        rd_mapped = {1'b0, ar_idx} < MAP_END;
        for (int i = 0; i < N_CTRL; i++) begin
            if (ar_idx == IDX_W'(i))
                rd_val = ctrl_q[32*i +: 32];
        end
        for (int j = 0; j < N_STAT; j++) begin
            if (ar_idx == IDX_W'(N_CTRL + j))
                rd_val = stat_src[32*j +: 32];
        end
    end

    always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
        if (!AXI_Rstn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= 2'b00;
        end else if (AXI_arvalid && AXI_arready) begin
            rvalid <= 1'b1;
            rdata  <= rd_mapped ? rd_val : 32'h0;
            rresp  <= rd_mapped ? 2'b00 : 2'b10;
        end else if (rvalid && AXI_rready) begin
            rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_eth_axil_regs.sv
// Directed bench for eth_axil_regs (default ADDR_W=8, N_CTRL=N_STAT=4); status section follows ETH_AXIL_W1C_EN.
module tb_eth_axil_regs;
    logic         AXI_Clk = 1'b0;
    logic         AXI_Rstn;
    logic         AXI_awvalid, AXI_awready;
    logic [7:0]   AXI_awaddr;
    logic         AXI_wvalid, AXI_wready;
    logic [31:0]  AXI_wdata;
    logic [3:0]   AXI_wstrb;
    logic         AXI_bvalid;
    logic [1:0]   AXI_bresp;
    logic         AXI_bready;
    logic         AXI_arvalid, AXI_arready;
    logic [7:0]   AXI_araddr;
    logic         AXI_rvalid;
    logic [31:0]  AXI_rdata;
    logic [1:0]   AXI_rresp;
    logic         AXI_rready;
    logic [127:0] Ctrl_Regs;
    logic [3:0]   Ctrl_Wr_Pulse;
    logic [127:0] Stat_In;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 AXI_Clk = ~AXI_Clk;

    eth_axil_regs #(.ADDR_W(8), .N_CTRL(4), .N_STAT(4)) dut (
        .AXI_Clk(AXI_Clk), .AXI_Rstn(AXI_Rstn),
        .AXI_awvalid(AXI_awvalid), .AXI_awready(AXI_awready), .AXI_awaddr(AXI_awaddr),
        .AXI_wvalid(AXI_wvalid), .AXI_wready(AXI_wready), .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb),
        .AXI_bvalid(AXI_bvalid), .AXI_bresp(AXI_bresp), .AXI_bready(AXI_bready),
        .AXI_arvalid(AXI_arvalid), .AXI_arready(AXI_arready), .AXI_araddr(AXI_araddr),
        .AXI_rvalid(AXI_rvalid), .AXI_rdata(AXI_rdata), .AXI_rresp(AXI_rresp), .AXI_rready(AXI_rready),
        .Ctrl_Regs(Ctrl_Regs), .Ctrl_Wr_Pulse(Ctrl_Wr_Pulse), .Stat_In(Stat_In)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the B handshake.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [3:0] pulse);
        bit aw_done, w_done, got_b;
        aw_done = 0; w_done = 0; got_b = 0;
        resp = 2'b11; pulse = 4'h0;
        AXI_awaddr = addr; AXI_wdata = data; AXI_wstrb = strb;
        AXI_awvalid = 1; AXI_wvalid = 1; AXI_bready = 1;
        for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
            if (AXI_awready) aw_done = 1;
            if (AXI_wready)  w_done = 1;
            @(negedge AXI_Clk);
            if (aw_done) AXI_awvalid = 0;
            if (w_done)  AXI_wvalid = 0;
        end
        for (int c = 0; c < 20 && !got_b; c++) begin
            if (AXI_bvalid) begin
                got_b = 1; resp = AXI_bresp; pulse = Ctrl_Wr_Pulse;
            end
            @(negedge AXI_Clk);
        end
        AXI_awvalid = 0; AXI_wvalid = 0; AXI_bready = 0;
        check("b_arrived", got_b, 1);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ar_done, got_r;
        ar_done = 0; got_r = 0;
        data = 32'hxxxxxxxx; resp = 2'b11;
        AXI_araddr = addr; AXI_arvalid = 1; AXI_rready = 1;
        for (int c = 0; c < 20 && !ar_done; c++) begin
            if (AXI_arready) ar_done = 1;
            @(negedge AXI_Clk);
            if (ar_done) AXI_arvalid = 0;
        end
        for (int c = 0; c < 20 && !got_r; c++) begin
            if (AXI_rvalid) begin
                got_r = 1; data = AXI_rdata; resp = AXI_rresp;
            end
            @(negedge AXI_Clk);
        end
        AXI_arvalid = 0; AXI_rready = 0;
        check("r_arrived", got_r, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [3:0]  pulse;
        logic [31:0] data;
        logic [31:0] exp_ctrl [4];
        int          bcount;

        AXI_Rstn = 0;
        AXI_awvalid = 0; AXI_awaddr = 0; AXI_wvalid = 0; AXI_wdata = 0; AXI_wstrb = 0;
        AXI_bready = 0; AXI_arvalid = 0; AXI_araddr = 0; AXI_rready = 0; Stat_In = '0;
        for (int i = 0; i < 4; i++) exp_ctrl[i] = 32'h0;
        repeat (2) @(negedge AXI_Clk);

        check("rst_readies", {AXI_awready, AXI_wready, AXI_arready}, 3'b000);
        check("rst_valids",  {AXI_bvalid, AXI_rvalid, AXI_bresp, AXI_rresp, Ctrl_Wr_Pulse}, 0);
        check("rst_ctrl",    Ctrl_Regs, 0);
        check("rst_rdata",   AXI_rdata, 0);
        AXI_Rstn = 1;
        #1 check("rel_readies", {AXI_awready, AXI_wready, AXI_arready}, 3'b111);
        @(negedge AXI_Clk);

        // Same-cycle AW+W to reg1, with a read of reg1 hitting the commit edge.
        AXI_awaddr = 8'h04; AXI_wdata = 32'hDEADBEEF; AXI_wstrb = 4'hF;
        AXI_awvalid = 1; AXI_wvalid = 1; AXI_bready = 1;
        check("aw_w_ready", {AXI_awready, AXI_wready}, 2'b11);
        @(negedge AXI_Clk);
        AXI_awvalid = 0; AXI_wvalid = 0;
        check("held_readies", {AXI_awready, AXI_wready, AXI_bvalid}, 3'b000);
        AXI_araddr = 8'h04; AXI_arvalid = 1; AXI_rready = 0;
        @(negedge AXI_Clk);
        AXI_arvalid = 0;
        exp_ctrl[1] = 32'hDEADBEEF;
        check("b_after_1", {AXI_bvalid, AXI_bresp}, 3'b100);
        check("reg1_val",  Ctrl_Regs[63:32], 32'hDEADBEEF);
        check("pulse_r1",  Ctrl_Wr_Pulse, 4'b0010);
        check("rd_prewr",  {AXI_rvalid, AXI_rresp, AXI_rdata}, {1'b1, 2'b00, 32'h0});
        AXI_rready = 1;
        @(negedge AXI_Clk);
        check("after_hs",  {AXI_bvalid, AXI_rvalid, Ctrl_Wr_Pulse}, 0);
        check("ready_back", {AXI_awready, AXI_wready, AXI_arready}, 3'b111);
        AXI_bready = 0; AXI_rready = 0;

        // W three cycles ahead of AW.
        axi_write(8'h00, 32'h11223344, 4'hF, resp, pulse);
        exp_ctrl[0] = 32'h11223344;
        check("wr0_pulse", pulse, 4'b0001);
        AXI_wdata = 32'h000000AA; AXI_wstrb = 4'h1; AXI_wvalid = 1; AXI_bready = 1;
        @(negedge AXI_Clk);
        AXI_wvalid = 0;
        @(negedge AXI_Clk);
        check("w_only_state", {AXI_bvalid, AXI_wready, AXI_awready}, 3'b001);
        @(negedge AXI_Clk);
        AXI_awaddr = 8'h00; AXI_awvalid = 1;
        @(negedge AXI_Clk);
        AXI_awvalid = 0;
        bcount = 0;
        for (int c = 0; c < 4; c++) begin
            if (AXI_bvalid) bcount++;
            @(negedge AXI_Clk);
        end
        AXI_bready = 0;
        exp_ctrl[0] = 32'h112233AA;
        check("w_first_bcnt", bcount, 1);
        check("w_first_reg0", Ctrl_Regs[31:0], 32'h112233AA);

        // Unmapped access.
        axi_read(8'hFC, data, resp);
        check("unmap_rd", {resp, data}, {2'b10, 32'h0});
        axi_write(8'hFC, 32'hFFFFFFFF, 4'hF, resp, pulse);
        check("unmap_wr", {resp, pulse}, {2'b10, 4'h0});
        check("unmap_regs", Ctrl_Regs, {exp_ctrl[3], exp_ctrl[2], exp_ctrl[1], exp_ctrl[0]});

        // Zero and partial strobes, and byte-offset addresses.
        axi_write(8'h0C, 32'hFFFFFFFF, 4'h0, resp, pulse);
        check("strb0_resp", {resp, pulse}, {2'b00, 4'b1000});
        check("strb0_regs", Ctrl_Regs, {exp_ctrl[3], exp_ctrl[2], exp_ctrl[1], exp_ctrl[0]});
        axi_write(8'h08, 32'hA5A5A5A5, 4'b0101, resp, pulse);
        exp_ctrl[2] = 32'h00A500A5;
        axi_read(8'h08, data, resp);
        check("part_strb", {resp, data}, {2'b00, 32'h00A500A5});
        axi_read(8'h05, data, resp);
        check("addr_lsb", {resp, data}, {2'b00, 32'hDEADBEEF});

        // B backpressure.
        AXI_awaddr = 8'h0C; AXI_wdata = 32'h12345678; AXI_wstrb = 4'hF;
        AXI_awvalid = 1; AXI_wvalid = 1; AXI_bready = 0;
        @(negedge AXI_Clk);
        AXI_awvalid = 0; AXI_wvalid = 0;
        @(negedge AXI_Clk);
        for (int c = 0; c < 5; c++) begin
            check("bp_hold", {AXI_bvalid, AXI_bresp, AXI_awready, AXI_wready}, 5'b10000);
            @(negedge AXI_Clk);
        end
        AXI_bready = 1;
        @(negedge AXI_Clk);
        AXI_bready = 0;
        exp_ctrl[3] = 32'h12345678;
        check("bp_release", {AXI_bvalid, AXI_awready, AXI_wready}, 3'b011);
        check("bp_regs", Ctrl_Regs, {exp_ctrl[3], exp_ctrl[2], exp_ctrl[1], exp_ctrl[0]});

`ifdef ETH_AXIL_W1C_EN
        Stat_In = 128'h1;
        @(negedge AXI_Clk);
        Stat_In = '0;
        @(negedge AXI_Clk);
        axi_read(8'h10, data, resp);
        check("w1c_sticky", {resp, data}, {2'b00, 32'h1});
        axi_write(8'h10, 32'h1, 4'hF, resp, pulse);
        check("w1c_wr_resp", {resp, pulse}, {2'b00, 4'h0});
        axi_read(8'h10, data, resp);
        check("w1c_cleared", data, 32'h0);
        AXI_awaddr = 8'h10; AXI_wdata = 32'h1; AXI_wstrb = 4'hF;
        AXI_awvalid = 1; AXI_wvalid = 1; AXI_bready = 1;
        @(negedge AXI_Clk);
        AXI_awvalid = 0; AXI_wvalid = 0; Stat_In = 128'h1;
        @(negedge AXI_Clk);
        Stat_In = '0;
        check("w1c_coinc_b", AXI_bvalid, 1'b1);
        @(negedge AXI_Clk);
        AXI_bready = 0;
        axi_read(8'h10, data, resp);
        check("w1c_coinc_set", data, 32'h1);
`else
        Stat_In = {32'h44444444, 32'h33333333, 32'h22222222, 32'h0000CAFE};
        @(negedge AXI_Clk);
        axi_read(8'h10, data, resp);
        check("stat0_rd", {resp, data}, {2'b00, 32'h0000CAFE});
        axi_read(8'h1C, data, resp);
        check("stat3_rd", {resp, data}, {2'b00, 32'h44444444});
        axi_write(8'h10, 32'hFFFFFFFF, 4'hF, resp, pulse);
        check("stat_wr", {resp, pulse}, {2'b00, 4'h0});
        check("stat_wr_regs", Ctrl_Regs, {exp_ctrl[3], exp_ctrl[2], exp_ctrl[1], exp_ctrl[0]});
        Stat_In = '0;
        @(negedge AXI_Clk);
        axi_read(8'h10, data, resp);
        check("stat_live", data, 32'h0);
`endif

        // Reset while a write response is pending.
        AXI_awaddr = 8'h00; AXI_wdata = 32'h55; AXI_wstrb = 4'hF;
        AXI_awvalid = 1; AXI_wvalid = 1; AXI_bready = 0;
        @(negedge AXI_Clk);
        AXI_awvalid = 0; AXI_wvalid = 0;
        @(negedge AXI_Clk);
        check("pre_rst_b", AXI_bvalid, 1'b1);
        AXI_Rstn = 0;
        #1;
        check("rst_mid_b", {AXI_bvalid, AXI_awready, AXI_wready, AXI_arready}, 4'b0000);
        check("rst_mid_ctrl", Ctrl_Regs, 0);
        @(negedge AXI_Clk);
        @(negedge AXI_Clk);
        AXI_Rstn = 1; AXI_bready = 1;
        #1 check("rst2_readies", {AXI_awready, AXI_wready, AXI_arready}, 3'b111);
        bcount = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge AXI_Clk);
            if (AXI_bvalid) bcount++;
        end
        AXI_bready = 0;
        check("rst_no_b", bcount, 0);
        check("rst_ctrl_end", Ctrl_Regs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eth_axil_regs.md
ETH_AXIL_REGS -- requirements
Module: eth_axil_regs

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, AXI-Lite byte-address width.
REQ-002 SHALL have parameter N_CTRL, default 4, number of read/write control registers (1..16).
REQ-003 SHALL have parameter N_STAT, default 4, number of status registers (1..16); N_CTRL+N_STAT <= 2**(ADDR_W-2).
REQ-004 AXI_Clk  in  1  single clock for all logic.
REQ-005 AXI_Rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 AXI_awvalid/AXI_awready  in/out  1/1  write-address handshake; AXI_awaddr  in  ADDR_W.
REQ-007 AXI_wvalid/AXI_wready  in/out  1/1  write-data handshake; AXI_wdata  in  32; AXI_wstrb  in  4.
REQ-008 AXI_bvalid  out  1;  AXI_bresp  out  2;  AXI_bready  in  1  write response.
REQ-009 AXI_arvalid/AXI_arready  in/out  1/1;  AXI_araddr  in  ADDR_W  read address.
REQ-010 AXI_rvalid  out  1;  AXI_rdata  out  32;  AXI_rresp  out  2;  AXI_rready  in  1  read data.
REQ-011 Ctrl_Regs  out  N_CTRL*32  control register contents, register i at bits [32i+31:32i].
REQ-012 Ctrl_Wr_Pulse  out  N_CTRL  one-cycle strobe, bit i set in the cycle after register i is written.
REQ-013 Stat_In  in  N_STAT*32  status inputs from Ethernet datapath, synchronous to AXI_Clk.

Function
REQ-014 Word index SHALL be addr[ADDR_W-1:2]; index 0..N_CTRL-1 control, N_CTRL..N_CTRL+N_STAT-1 status, anything else unmapped; addr[1:0] ignored.
REQ-015 AW and W channels SHALL be accepted independently, in either order or same cycle; each held in its own capture register.
REQ-016 AXI_awready SHALL be high iff no address held and AXI_bvalid low; AXI_wready likewise for data.
REQ-017 Write SHALL commit on the edge after both address and data are held (same-cycle AW+W at edge k: register and AXI_bvalid updated at edge k+1).
REQ-018 Control write SHALL update only bytes with wstrb set; wstrb=0 commits nothing but still responds OKAY and pulses Ctrl_Wr_Pulse.
REQ-019 AXI_bvalid SHALL hold with stable AXI_bresp until AXI_bready; captures freed on the B handshake edge, readies high the next cycle.
REQ-020 AXI_arready SHALL be high iff AXI_rvalid low; AR handshake at edge k gives AXI_rvalid, AXI_rdata, AXI_rresp at edge k+1, held stable until AXI_rready.
REQ-021 Unmapped read or write SHALL return resp 2'b10 (SLVERR), rdata 0, no register change; mapped access returns 2'b00.
REQ-022 Read and write paths SHALL be fully independent; a same-cycle read of a register being committed returns the pre-write value.
REQ-023 Writes to status indices behave per REQ-027/REQ-028.

Reset
REQ-024 While AXI_Rstn low: all ready/valid outputs 0, bresp/rresp 0, rdata 0, Ctrl_Regs 0, Ctrl_Wr_Pulse 0, status registers 0, captures cleared.
REQ-025 Readies SHALL assert in the first cycle after AXI_Rstn release.
REQ-026 Reset mid-transaction SHALL drop the transaction; no response issued after release.

Configuration
REQ-027 With ETH_AXIL_W1C_EN defined: status registers SHALL be sticky (stat <= stat | Stat_In each cycle); write clears bits where wdata=1 in enabled bytes; a bit set by Stat_In in the clear cycle stays set.
REQ-028 Without ETH_AXIL_W1C_EN: status reads return Stat_In sampled on the AR handshake edge; status writes ignored, resp OKAY.

Verification
REQ-029 Same-cycle AW addr 0x04 + W 0xDEADBEEF strb 0xF, bready=1 -> bvalid one cycle later bresp 00, Ctrl_Regs[63:32]=0xDEADBEEF, Ctrl_Wr_Pulse=4'b0010 for one cycle.
REQ-030 W 0x000000AA strb 0x1 three cycles before AW addr 0x00 (reg0=0x11223344) -> reg0=0x112233AA, single bvalid.
REQ-031 Read addr 0xFC (N_CTRL=N_STAT=4) -> rvalid, rresp 10, rdata 0; write there -> bresp 10, no register changes.
REQ-032 bready held low 5 cycles -> bvalid, bresp stable, awready/wready low throughout; readies high cycle after handshake.
REQ-033 W1C build: Stat_In[0] pulse 1 cycle, read 0x10 -> 0x1; write 0x1 to 0x10 -> reads 0x0; write coinciding with new Stat_In[0] pulse -> reads 0x1.
REQ-034 Assert AXI_Rstn low while bvalid pending -> bvalid 0 immediately, Ctrl_Regs 0, no response after release.
